// File: rtl/roce_tx_msg_aligner.sv
// Aligns RoCE TX meta/data streams: forwards each meta word, then exactly the data beats its length implies.
// Optional ROCE_TX_ALIGN_BYTECNT_EN adds a 64-bit forwarded-byte counter output.
module roce_tx_msg_aligner #(
    parameter int META_W  = 256,
    parameter int DATA_W  = 512,
    parameter int LEN_LSB = 155
) (
    input  logic                  ap_clk,
    input  logic                  areset,
    input  logic                  s_meta_tvalid,
    output logic                  s_meta_tready,
    input  logic [META_W-1:0]     s_meta_tdata,
    input  logic [META_W/8-1:0]   s_meta_tkeep,
    input  logic                  s_meta_tlast,
    input  logic                  s_data_tvalid,
    output logic                  s_data_tready,
    input  logic [DATA_W-1:0]     s_data_tdata,
    input  logic [DATA_W/8-1:0]   s_data_tkeep,
    input  logic                  s_data_tlast,
    output logic                  m_meta_tvalid,
    input  logic                  m_meta_tready,
    output logic [META_W-1:0]     m_meta_tdata,
    output logic [META_W/8-1:0]   m_meta_tkeep,
    output logic                  m_meta_tlast,
    output logic                  m_data_tvalid,
    input  logic                  m_data_tready,
    output logic [DATA_W-1:0]     m_data_tdata,
    output logic [DATA_W/8-1:0]   m_data_tkeep,
    output logic                  m_data_tlast,
    output logic [31:0]           msg_count,
    output logic [15:0]           err_short,
    output logic [15:0]           err_long,
    output logic                  busy
`ifdef ROCE_TX_ALIGN_BYTECNT_EN
    ,
    output logic [63:0]           byte_count
`endif
);

    localparam int KEEP_W  = DATA_W / 8;
    localparam int REM_W   = $clog2(KEEP_W);
    localparam int BEATS_W = 33 - REM_W;

    typedef enum logic [1:0] {IDLE, META, DATA, DRAIN} state_t;

    // All streams use AXI4-Stream semantics: a beat transfers on a rising
    // edge where tvalid and tready are both high; tvalid never waits on tready.
    state_t               state;
    logic [BEATS_W-1:0]   beats;
    logic [REM_W-1:0]     rem;
    logic [31:0]          beat_cnt;
    logic [31:0]          len_in;
    logic [BEATS_W-1:0]   beats_in;
    logic                 is_final;
    logic [KEEP_W-1:0]    rem_mask;

    assign len_in   = s_meta_tdata[LEN_LSB +: 32];
    assign beats_in = {1'b0, len_in[31:REM_W]} + {{(BEATS_W-1){1'b0}}, |len_in[REM_W-1:0]};
    assign is_final = (beat_cnt == (32'(beats) - 32'd1));
    assign rem_mask = (KEEP_W'(1) << rem) - KEEP_W'(1);

    assign m_data_tvalid = (state == DATA) && s_data_tvalid;
    assign s_data_tready = (state == DATA) ? m_data_tready : (state == DRAIN);
    assign m_data_tdata  = s_data_tdata;
    assign m_data_tlast  = is_final || s_data_tlast;
    assign m_data_tkeep  = (is_final && rem != '0) ? rem_mask : s_data_tkeep;
    assign busy          = (state != IDLE);

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            state         <= IDLE;
            s_meta_tready <= 1'b0;
            m_meta_tvalid <= 1'b0;
            msg_count     <= '0;
            err_short     <= '0;
            err_long      <= '0;
            beat_cnt      <= '0;
            beats         <= '0;
            rem           <= '0;
        end else begin
            case (state)
                IDLE: begin
                    s_meta_tready <= 1'b1;
                    if (s_meta_tvalid && s_meta_tready) begin
                        m_meta_tdata  <= s_meta_tdata;
                        m_meta_tkeep  <= s_meta_tkeep;
                        m_meta_tlast  <= s_meta_tlast;
                        beats         <= beats_in;
                        rem           <= len_in[REM_W-1:0];
                        s_meta_tready <= 1'b0;
                        m_meta_tvalid <= 1'b1;
                        state         <= META;
                    end
                end
                META: begin
                    if (m_meta_tready) begin
                        m_meta_tvalid <= 1'b0;
                        msg_count     <= msg_count + 32'd1;
                        beat_cnt      <= '0;
                        if (beats == '0) begin
                            state         <= IDLE;
                            s_meta_tready <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (s_data_tvalid && m_data_tready) begin
                        beat_cnt <= beat_cnt + 32'd1;
                        if (s_data_tlast) begin
                            state         <= IDLE;
                            s_meta_tready <= 1'b1;
                            if (!is_final && err_short != 16'hFFFF)
                                err_short <= err_short + 16'd1;
                        end else if (is_final) begin
                            state <= DRAIN;
                            if (err_long != 16'hFFFF)
                                err_long <= err_long + 16'd1;
                        end
                    end
                end
                DRAIN: begin
                    // Surplus upstream beats are swallowed until the burst ends.
                    if (s_data_tvalid && s_data_tlast) begin
                        state         <= IDLE;
                        s_meta_tready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ROCE_TX_ALIGN_BYTECNT_EN
    logic [REM_W:0] keep_ones;

    always_comb begin
        keep_ones = '0;
        for (int i = 0; i < KEEP_W; i++)
            keep_ones = keep_ones + {{REM_W{1'b0}}, m_data_tkeep[i]};
    end

    always_ff @(posedge ap_clk) begin
        if (areset)
            byte_count <= '0;
        else if (m_data_tvalid && m_data_tready)
            byte_count <= byte_count + 64'(keep_ones);
    end
`endif

endmodule

// File: tb/tb_roce_tx_msg_aligner.sv
// Directed bench for roce_tx_msg_aligner: meta/data ordering, tlast/tkeep regeneration, error counters, reset.
module tb_roce_tx_msg_aligner;

    localparam int META_W  = 256;
    localparam int DATA_W  = 512;
    localparam int LEN_LSB = 155;
    localparam int BW      = 129;

    logic                ap_clk;
    logic                areset;
    logic                s_meta_tvalid = 1'b0;
    logic                s_meta_tready;
    logic [META_W-1:0]   s_meta_tdata  = '0;
    logic [META_W/8-1:0] s_meta_tkeep  = '1;
    logic                s_meta_tlast  = 1'b1;
    logic                s_data_tvalid = 1'b0;
    logic                s_data_tready;
    logic [DATA_W-1:0]   s_data_tdata  = '0;
    logic [DATA_W/8-1:0] s_data_tkeep  = '1;
    logic                s_data_tlast  = 1'b0;
    logic                m_meta_tvalid;
    logic                m_meta_tready = 1'b1;
    logic [META_W-1:0]   m_meta_tdata;
    logic [META_W/8-1:0] m_meta_tkeep;
    logic                m_meta_tlast;
    logic                m_data_tvalid;
    logic                m_data_tready = 1'b1;
    logic [DATA_W-1:0]   m_data_tdata;
    logic [DATA_W/8-1:0] m_data_tkeep;
    logic                m_data_tlast;
    logic [31:0]         msg_count;
    logic [15:0]         err_short;
    logic [15:0]         err_long;
    logic                busy;
`ifdef ROCE_TX_ALIGN_BYTECNT_EN
    logic [63:0]         byte_count;
`endif

    roce_tx_msg_aligner #(.META_W(META_W), .DATA_W(DATA_W), .LEN_LSB(LEN_LSB)) dut (
        .ap_clk(ap_clk), .areset(areset),
        .s_meta_tvalid(s_meta_tvalid), .s_meta_tready(s_meta_tready), .s_meta_tdata(s_meta_tdata),
        .s_meta_tkeep(s_meta_tkeep), .s_meta_tlast(s_meta_tlast),
        .s_data_tvalid(s_data_tvalid), .s_data_tready(s_data_tready), .s_data_tdata(s_data_tdata),
        .s_data_tkeep(s_data_tkeep), .s_data_tlast(s_data_tlast),
        .m_meta_tvalid(m_meta_tvalid), .m_meta_tready(m_meta_tready), .m_meta_tdata(m_meta_tdata),
        .m_meta_tkeep(m_meta_tkeep), .m_meta_tlast(m_meta_tlast),
        .m_data_tvalid(m_data_tvalid), .m_data_tready(m_data_tready), .m_data_tdata(m_data_tdata),
        .m_data_tkeep(m_data_tkeep), .m_data_tlast(m_data_tlast),
        .msg_count(msg_count), .err_short(err_short), .err_long(err_long), .busy(busy)
`ifdef ROCE_TX_ALIGN_BYTECNT_EN
        , .byte_count(byte_count)
`endif
    );

    // clock / reset
    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    int          checks = 0;
    int          errors = 0;
    int unsigned tag_ctr = 32'h100;
    bit          bp_en = 1'b0;

    logic [BW-1:0]     exp_q[$];
    logic [BW-1:0]     got_q[$];
    logic [META_W-1:0] exp_meta_q[$];
    logic [META_W-1:0] got_meta_q[$];

    // backpressure source: sole driver of the downstream treadys
    always @(posedge ap_clk) begin
        #1;
        m_meta_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        m_data_tready = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    // monitor: sample on the falling edge, i.e. the values the next rising edge transfers
    always @(negedge ap_clk) begin
        if (!areset && m_meta_tvalid && m_meta_tready)
            got_meta_q.push_back(m_meta_tdata);
        if (!areset && m_data_tvalid && m_data_tready)
            got_q.push_back({m_data_tlast, m_data_tkeep, m_data_tdata[DATA_W-1 -: 32], m_data_tdata[31:0]});
    end

    task automatic step();
        @(posedge ap_clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] tag, input logic [63:0] keep, input logic last);
        exp_q.push_back({last, keep, tag, tag});
    endtask

    // driver tasks
    task automatic send_meta(input logic [31:0] len);
        logic [META_W-1:0] md;
        int n;
        md = '0;
        md[31:0] = $urandom();
        md[255:224] = $urandom();
        md[LEN_LSB +: 32] = len;
        s_meta_tdata = md;
        s_meta_tvalid = 1'b1;
        n = 0;
        while (!s_meta_tready && n < 200) begin
            step();
            n++;
        end
        check("meta_ready_timeout", 256'(s_meta_tready), 256'(1));
        step();
        s_meta_tvalid = 1'b0;
        exp_meta_q.push_back(md);
    endtask

    task automatic send_data(input int nbeats, input int last_at);
        int n;
        for (int i = 0; i < nbeats; i++) begin
            s_data_tdata = {16{32'(tag_ctr)}};
            s_data_tlast = (i + 1 == last_at);
            s_data_tvalid = 1'b1;
            tag_ctr++;
            n = 0;
            while (!s_data_tready && n < 200) begin
                step();
                n++;
            end
            if (n >= 200) begin
                check("data_ready_timeout", 256'(s_data_tready), 256'(1));
                break;
            end
            step();
        end
        s_data_tvalid = 1'b0;
        s_data_tlast = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 500) begin
            step();
            n++;
        end
        check("idle_timeout", 256'(busy), 256'(0));
    endtask

    // scoreboard compare
    task automatic compare_sb(input string tag);
        check({tag, "_beats"}, 256'(got_q.size()), 256'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0)
            check({tag, "_beat"}, 256'(got_q.pop_front()), 256'(exp_q.pop_front()));
        check({tag, "_metas"}, 256'(got_meta_q.size()), 256'(exp_meta_q.size()));
        while (got_meta_q.size() > 0 && exp_meta_q.size() > 0)
            check({tag, "_meta"}, got_meta_q.pop_front(), exp_meta_q.pop_front());
        got_q.delete();
        exp_q.delete();
        got_meta_q.delete();
        exp_meta_q.delete();
    endtask

    task automatic run_msg(input logic [31:0] len);
        int nb;
        int r;
        logic [64:0] one;
        logic [64:0] mask;
        send_meta(len);
        nb = (int'(len) + 63) / 64;
        r = int'(len) % 64;
        one = 65'd1;
        mask = (one << r) - 65'd1;
        for (int i = 0; i < nb; i++)
            push_exp(tag_ctr + 32'(i), (i == nb - 1 && r != 0) ? mask[63:0] : '1, i == nb - 1);
        if (nb > 0)
            send_data(nb, nb);
        wait_idle();
    endtask

    initial begin
        logic [31:0] base;

        // reset state
        areset = 1'b1;
        step(); step(); step();
        check("rst_s_meta_tready", 256'(s_meta_tready), 256'(0));
        check("rst_s_data_tready", 256'(s_data_tready), 256'(0));
        check("rst_m_meta_tvalid", 256'(m_meta_tvalid), 256'(0));
        check("rst_m_data_tvalid", 256'(m_data_tvalid), 256'(0));
        check("rst_msg_count", 256'(msg_count), 256'(0));
        check("rst_err_short", 256'(err_short), 256'(0));
        check("rst_err_long", 256'(err_long), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        areset = 1'b0;
        step();

        // len=128: two full beats, tlast on beat 2
        run_msg(32'd128);
        compare_sb("len128");
        check("len128_msg_count", 256'(msg_count), 256'(1));
        check("len128_err_short", 256'(err_short), 256'(0));
        check("len128_err_long", 256'(err_long), 256'(0));
        check("len128_meta_tkeep", 256'(m_meta_tkeep), 256'(32'hFFFF_FFFF));
        check("len128_meta_tlast", 256'(m_meta_tlast), 256'(1));
`ifdef ROCE_TX_ALIGN_BYTECNT_EN
        check("len128_byte_count", 256'(byte_count), 256'(128));
`endif

        // len=100: last beat keeps 36 bytes
        send_meta(32'd100);
        push_exp(tag_ctr, '1, 1'b0);
        push_exp(tag_ctr + 1, 64'h0000_000F_FFFF_FFFF, 1'b1);
        send_data(2, 2);
        wait_idle();
        compare_sb("len100");
        check("len100_msg_count", 256'(msg_count), 256'(2));
`ifdef ROCE_TX_ALIGN_BYTECNT_EN
        check("len100_byte_count", 256'(byte_count), 256'(228));
`endif

        // len=0: meta only, data never accepted
        send_meta(32'd0);
        s_data_tvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("len0_s_data_tready", 256'(s_data_tready), 256'(0));
            step();
        end
        s_data_tvalid = 1'b0;
        wait_idle();
        compare_sb("len0");
        check("len0_msg_count", 256'(msg_count), 256'(3));

        // len=256, upstream ends after beat 2: short burst
        send_meta(32'd256);
        push_exp(tag_ctr, '1, 1'b0);
        push_exp(tag_ctr + 1, '1, 1'b1);
        send_data(2, 2);
        check("short_next_meta_ready", 256'(s_meta_tready), 256'(1));
        check("short_busy", 256'(busy), 256'(0));
        check("short_err_short", 256'(err_short), 256'(1));
        check("short_err_long", 256'(err_long), 256'(0));
        compare_sb("short");

        // len=64, upstream sends 3 beats: long burst, beats 2-3 drained
        send_meta(32'd64);
        push_exp(tag_ctr, '1, 1'b1);
        send_data(3, 3);
        wait_idle();
        compare_sb("long");
        check("long_err_long", 256'(err_long), 256'(1));
        check("long_err_short", 256'(err_short), 256'(1));
        check("long_msg_count", 256'(msg_count), 256'(5));

        // 50 well-formed messages under random downstream backpressure
        bp_en = 1'b1;
        for (int m = 0; m < 50; m++)
            run_msg(32'($urandom_range(0, 400)));
        bp_en = 1'b0;
        step();
        compare_sb("random");
        check("random_msg_count", 256'(msg_count), 256'(55));
        check("random_err_short", 256'(err_short), 256'(1));
        check("random_err_long", 256'(err_long), 256'(1));

        // reset asserted mid-DATA
        send_meta(32'd640);
        base = tag_ctr;
        for (int i = 0; i < 3; i++)
            push_exp(base + 32'(i), '1, 1'b0);
        send_data(3, 0);
        compare_sb("pre_reset");
        check("pre_reset_busy", 256'(busy), 256'(1));
        s_data_tdata = {16{32'(tag_ctr)}};
        s_data_tvalid = 1'b1;
        areset = 1'b1;
        step();
        check("midrst_m_data_tvalid", 256'(m_data_tvalid), 256'(0));
        check("midrst_m_meta_tvalid", 256'(m_meta_tvalid), 256'(0));
        check("midrst_s_meta_tready", 256'(s_meta_tready), 256'(0));
        check("midrst_s_data_tready", 256'(s_data_tready), 256'(0));
        check("midrst_msg_count", 256'(msg_count), 256'(0));
        check("midrst_err_short", 256'(err_short), 256'(0));
        check("midrst_err_long", 256'(err_long), 256'(0));
        check("midrst_busy", 256'(busy), 256'(0));
        s_data_tvalid = 1'b0;
        areset = 1'b0;
        step();
        got_q.delete();

        // recovery after reset
        run_msg(32'd64);
        compare_sb("post_reset");
        check("post_reset_msg_count", 256'(msg_count), 256'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
